id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage core; sits directly upstream of the ALU and feeds its A, B and 4-bit ALUOp inputs.
- Captures decoded operands and control on a valid/ready handshake.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, holds decode, and inserts a one-cycle bubble.

---
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: valid/ready capture, load-use bubble, flush, EX/MEM and MEM/WB forwarding.
// Optional macro ID_EX_FWD_EN enables forwarding; when undefined, any in-flight producer stalls its consumer.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [3:0]        in_alu_op,
  input  logic              in_alu_src_imm,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [XLEN-1:0]   store_data,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rd;
  logic [3:0]        r_alu_op;
  logic              r_alu_src_imm;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;

  logic              w_load;
  logic              w_lu_stall;
  logic              w_src_match;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;

  // Incoming instruction reads the register the held instruction will write
  assign w_src_match = (in_rs1_addr == r_rd) ||
                       ((in_rs2_addr == r_rd) && !in_alu_src_imm);

`ifdef ID_EX_FWD_EN
  assign w_lu_stall = r_valid && r_mem_read && (r_rd != '0) && in_valid && w_src_match;

  // EX/MEM has priority over MEM/WB; x0 is never forwarded
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    w_fwd_rs2 = r_rs2_data;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == r_rs1_addr))
      w_fwd_rs1 = exm_data;
    else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == r_rs1_addr))
      w_fwd_rs1 = mwb_data;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == r_rs2_addr))
      w_fwd_rs2 = exm_data;
    else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == r_rs2_addr))
      w_fwd_rs2 = mwb_data;
  end
`else
  logic w_unused_fwd;

  // Without bypass paths any held producer blocks a dependent consumer
  assign w_lu_stall = r_valid && (r_mem_read || r_reg_write) && (r_rd != '0) &&
                      in_valid && w_src_match;
  assign w_fwd_rs1  = r_rs1_data;
  assign w_fwd_rs2  = r_rs2_data;
  assign w_unused_fwd = ^{exm_reg_write, exm_rd, exm_data, mwb_reg_write, mwb_rd,
                          mwb_data, r_rs1_addr, r_rs2_addr};
`endif

  assign in_ready = (!r_valid || out_ready) && !w_lu_stall && !flush;
  assign w_load   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_rs1_addr    <= '0;
      r_rs2_addr    <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_rd          <= '0;
      r_alu_op      <= '0;
      r_alu_src_imm <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid       <= 1'b1;
      r_pc          <= in_pc;
      r_rs1_addr    <= in_rs1_addr;
      r_rs2_addr    <= in_rs2_addr;
      r_rs1_data    <= in_rs1_data;
      r_rs2_data    <= in_rs2_data;
      r_imm         <= in_imm;
      r_rd          <= in_rd_addr;
      r_alu_op      <= in_alu_op;
      r_alu_src_imm <= in_alu_src_imm;
      r_reg_write   <= in_reg_write;
      r_mem_read    <= in_mem_read;
      r_mem_write   <= in_mem_write;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign alu_a         = w_fwd_rs1;
  assign alu_b         = r_alu_src_imm ? r_imm : w_fwd_rs2;
  assign store_data    = w_fwd_rs2;
  assign alu_op        = r_alu_op;
  assign out_pc        = r_pc;
  assign out_rd        = r_rd;
  assign out_reg_write = r_reg_write & r_valid;
  assign out_mem_read  = r_mem_read  & r_valid;
  assign out_mem_write = r_mem_write & r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/forwarding cases plus a scoreboarded stream.
module tb_id_ex_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int          N_STREAM = 20;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [4:0]  rd;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [XLEN-1:0]   in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [REG_AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0]        in_alu_op;
  logic              in_alu_src_imm, in_reg_write, in_mem_read, in_mem_write;
  logic              flush;
  logic              exm_reg_write, mwb_reg_write;
  logic [REG_AW-1:0] exm_rd, mwb_rd;
  logic [XLEN-1:0]   exm_data, mwb_data;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   alu_a, alu_b, store_data, out_pc;
  logic [3:0]        alu_op;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write, out_mem_read, out_mem_write;

  int n_checks = 0;
  int n_fails  = 0;
  exp_t q[$];

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_rd_addr(in_rd_addr), .in_alu_op(in_alu_op),
    .in_alu_src_imm(in_alu_src_imm), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data), .alu_op(alu_op),
    .out_pc(out_pc), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_pc = '0; in_rs1_addr = '0; in_rs2_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_rd_addr = '0;
    in_alu_op = '0; in_alu_src_imm = 1'b0; in_reg_write = 1'b0;
    in_mem_read = 1'b0; in_mem_write = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [3:0] op, input logic si,
                       input logic rw, input logic mr, input logic mw);
    in_valid = 1'b1; in_pc = pc; in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_rd_addr = rd;
    in_alu_op = op; in_alu_src_imm = si; in_reg_write = rw;
    in_mem_read = mr; in_mem_write = mw;
  endtask

  task automatic fwd_idle();
    exm_reg_write = 1'b0; exm_rd = '0; exm_data = '0;
    mwb_reg_write = 1'b0; mwb_rd = '0; mwb_data = '0;
  endtask

  initial begin
    exp_t e;
    exp_t got;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle(); fwd_idle();

    // Power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // ADDI x5, x1, 0x10 with downstream stalled
    drive(32'h100, 5'd1, 5'd0, 32'h20, 32'h0, 32'h10, 5'd5, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("addi_in_ready", 32'(in_ready), 32'd1);
    step();
    idle();
    @(negedge clk);
    check_eq("addi_valid", 32'(out_valid), 32'd1);
    check_eq("addi_alu_a", alu_a, 32'h20);
    check_eq("addi_alu_b", alu_b, 32'h10);
    check_eq("addi_alu_op", 32'(alu_op), 32'd0);
    check_eq("addi_rd", 32'(out_rd), 32'd5);
    check_eq("addi_rw", 32'(out_reg_write), 32'd1);
    drive(32'h104, 5'd12, 5'd13, 32'h1, 32'h2, 32'h3, 5'd14, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) step();
    @(negedge clk);
    check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    check_eq("hold_valid", 32'(out_valid), 32'd1);
    check_eq("hold_alu_a", alu_a, 32'h20);
    check_eq("hold_pc", out_pc, 32'h100);
    idle();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check_eq("drain_valid", 32'(out_valid), 32'd0);

    // Forwarding onto a held instruction (rs1=x3, rs2=x4)
    out_ready = 1'b0;
    drive(32'h200, 5'd3, 5'd4, 32'h1111, 32'h4444, 32'h0, 5'd6, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    exm_reg_write = 1'b1; exm_rd = 5'd3; exm_data = 32'hAAAA;
    mwb_reg_write = 1'b1; mwb_rd = 5'd3; mwb_data = 32'hBBBB;
    @(negedge clk);
`ifdef ID_EX_FWD_EN
    check_eq("fwd_exm_prio", alu_a, 32'hAAAA);
`else
    check_eq("nofwd_exm", alu_a, 32'h1111);
`endif
    exm_reg_write = 1'b0;
    #1;
`ifdef ID_EX_FWD_EN
    check_eq("fwd_mwb", alu_a, 32'hBBBB);
`else
    check_eq("nofwd_mwb", alu_a, 32'h1111);
`endif
    exm_reg_write = 1'b1; exm_rd = 5'd4; exm_data = 32'hCCCC; mwb_rd = 5'd0;
    #1;
`ifdef ID_EX_FWD_EN
    check_eq("fwd_rs2_b", alu_b, 32'hCCCC);
    check_eq("fwd_rs2_sd", store_data, 32'hCCCC);
`else
    check_eq("nofwd_rs2_b", alu_b, 32'h4444);
    check_eq("nofwd_rs2_sd", store_data, 32'h4444);
`endif
    exm_rd = 5'd0; mwb_rd = 5'd0;
    #1;
    check_eq("fwd_rd0", alu_a, 32'h1111);
    fwd_idle();
    out_ready = 1'b1;
    step();

    // Source x0 must never pick up a forwarded value
    out_ready = 1'b0;
    drive(32'h240, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd6, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_data = 32'hAAAA;
    mwb_reg_write = 1'b1; mwb_rd = 5'd0; mwb_data = 32'hBBBB;
    @(negedge clk);
    check_eq("x0_no_fwd", alu_a, 32'h0);
    fwd_idle();
    out_ready = 1'b1;
    step();

    // Load-use: LW x7 held, ADD x9, x7, x8 behind it
    drive(32'h280, 5'd2, 5'd0, 32'h100, 32'h0, 32'h4, 5'd7, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(32'h284, 5'd7, 5'd8, 32'h55, 32'h66, 32'h0, 5'd9, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("lu_in_ready", 32'(in_ready), 32'd0);
    check_eq("lu_load_mr", 32'(out_mem_read), 32'd1);
    step();
    @(negedge clk);
    check_eq("lu_bubble_valid", 32'(out_valid), 32'd0);
    check_eq("lu_bubble_rw", 32'(out_reg_write), 32'd0);
    check_eq("lu_retry_ready", 32'(in_ready), 32'd1);
    step();
    idle();
    @(negedge clk);
    check_eq("lu_add_valid", 32'(out_valid), 32'd1);
    check_eq("lu_add_rd", 32'(out_rd), 32'd9);
    check_eq("lu_add_a", alu_a, 32'h55);

    // Non-load producer ADD x9 held, consumer reads x9
    drive(32'h288, 5'd9, 5'd1, 32'h0, 32'h0, 32'h0, 5'd10, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef ID_EX_FWD_EN
    check_eq("alu_dep_ready", 32'(in_ready), 32'd1);
`else
    check_eq("alu_dep_ready", 32'(in_ready), 32'd0);
`endif
    idle();
    step();
    @(negedge clk);
    check_eq("alu_dep_drain", 32'(out_valid), 32'd0);

    // Flush kills the held instruction and blocks the incoming one
    out_ready = 1'b0;
    drive(32'h300, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 5'd10, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    drive(32'h400, 5'd3, 5'd4, 32'h3, 32'h4, 32'h0, 5'd11, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", 32'(in_ready), 32'd0);
    check_eq("flush_pre_mw", 32'(out_mem_write), 32'd1);
    step();
    flush = 1'b0;
    idle();
    @(negedge clk);
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_mw", 32'(out_mem_write), 32'd0);
    check_eq("flush_pc", out_pc, 32'h300);

    // Back-to-back stream through the scoreboard
    out_ready = 1'b1;
    step();
    for (int i = 0; i <= N_STREAM; i++) begin
      if (i < N_STREAM) begin
        e.pc = 32'h1000 + 32'(i * 4);
        e.rd = 5'(20 + $urandom_range(0, 5));
        e.op = 4'($urandom_range(0, 8));
        drive(e.pc, 5'(10 + $urandom_range(0, 5)), 5'(10 + $urandom_range(0, 5)),
              $urandom, $urandom, $urandom, e.rd, e.op, 1'($urandom_range(0, 1)),
              1'b1, 1'b0, 1'b0);
        e.a  = in_rs1_data;
        e.sd = in_rs2_data;
        e.b  = in_alu_src_imm ? in_imm : in_rs2_data;
      end else begin
        idle();
      end
      @(negedge clk);
      if (i > 0) begin
        check_eq("stream_valid", 32'(out_valid), 32'd1);
        if (out_valid && q.size() > 0) begin
          got = q.pop_front();
          check_eq("sb_alu_a", alu_a, got.a);
          check_eq("sb_alu_b", alu_b, got.b);
          check_eq("sb_store", store_data, got.sd);
          check_eq("sb_pc", out_pc, got.pc);
          check_eq("sb_op", 32'(alu_op), 32'(got.op));
          check_eq("sb_rd", 32'(out_rd), 32'(got.rd));
        end
      end
      if (i < N_STREAM) begin
        check_eq("stream_ready", 32'(in_ready), 32'd1);
        if (in_ready) q.push_back(e);
      end
      step();
    end
    @(negedge clk);
    check_eq("sb_empty", 32'(q.size()), 32'd0);
    check_eq("stream_end_valid", 32'(out_valid), 32'd0);

    // Reset asserted mid-transfer
    out_ready = 1'b0;
    drive(32'h500, 5'd1, 5'd2, 32'h77, 32'h88, 32'h0, 5'd12, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    #2;
    check_eq("mid_valid_pre", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_op", 32'(alu_op), 32'd0);
    check_eq("mid_rst_rd", 32'(out_rd), 32'd0);
    check_eq("mid_rst_a", alu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_valid2", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
